// File: rtl/ser_tx_pkg.sv
// ser_tx_pkg -- shared types and constants for the ser_tx serializer.
//
// Contents:
//   state_t        FSM state enum (IDLE, SHIFT, GAP).
//   DEF_WIDTH      default payload width.
//   DEF_GAP_BITS   default idle bit-times between words.
//   calc_nbits()   serial bits per word: WIDTH, plus one when the
//                  SER_TX_PARITY_EN macro adds the even-parity bit.
package ser_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_GAP_BITS = 2;

    function automatic int calc_nbits(input int width);
`ifdef SER_TX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/ser_tx_bitclk.sv
// ser_tx_bitclk -- bit-time generator for ser_tx.
//
// Each serial bit lasts two clk cycles: phase 0 (lane clock low) then
// phase 1 (lane clock high). This block toggles the phase while the
// shifter runs and counts bits 0..NBITS-1, raising o_last during
// phase 1 of the final bit.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_start  in   word accepted this cycle; restart at bit 0 / phase 0
//   i_run    in   shifter is in its SHIFT state
//   o_phase  out  current bit phase (0 = low half, 1 = high half)
//   o_cnt    out  index of the bit currently on the lane
//   o_last   out  phase 1 of bit NBITS-1 (word ends after this cycle)
module ser_tx_bitclk #(
    parameter int NBITS = 16,
    parameter int CW    = $clog2(NBITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_run,
    output logic          o_phase,
    output logic [CW-1:0] o_cnt,
    output logic          o_last
);

    localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

    logic          r_phase;
    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = r_phase && (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_phase <= 1'b0;
            r_cnt   <= '0;
        end else if (i_run) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                // Clear at the terminal bit so the counter never wraps.
                if (w_last) r_cnt <= '0;
                else        r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_phase <= 1'b0;
            r_cnt   <= '0;
        end
    end

    assign o_phase = r_phase;
    assign o_cnt   = r_cnt;
    assign o_last  = w_last;

endmodule

// File: rtl/ser_tx.sv
// ser_tx -- parallel-to-serial lane transmitter with forwarded clock.
//
// A word is accepted from data_in, then sent one bit per two clk
// cycles on tx_data, with tx_clk low for the first cycle of each bit
// and high for the second (receiver samples on the tx_clk rising
// edge). After the word the lane idles low for 2*GAP_BITS cycles,
// then one IDLE cycle, so back-to-back words repeat every
// 2*NBITS + 2*GAP_BITS + 1 cycles.
//
// Handshake: ready_out = (state == IDLE) && ena. A word transfers on
// any rising clk edge where valid_in && ready_out; data_in and
// lsb_first are captured on that edge only. Dropping ena never aborts
// a word already accepted.
//
// Optional feature: define SER_TX_PARITY_EN to append an even-parity
// bit (XOR of the payload) after the last payload bit, in either bit
// order. Without it no parity logic is built.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   ena            in   enables acceptance of new words
//   data_in        in   word to send (WIDTH bits)
//   valid_in       in   data_in valid
//   ready_out      out  a word can be accepted this cycle
//   lsb_first      in   bit order (0 = MSB first, 1 = LSB first)
//   tx_clk         out  forwarded lane clock
//   tx_data        out  serial lane data
//   busy           out  high whenever the FSM is not IDLE
//   o_dbg_state    out  current FSM state
//   o_dbg_bit_cnt  out  index of the bit currently on the lane
module ser_tx
    import ser_tx_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int GAP_BITS = DEF_GAP_BITS,
    localparam int NBITS    = calc_nbits(WIDTH),
    localparam int CW       = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             lsb_first,
    output logic             tx_clk,
    output logic             tx_data,
    output logic             busy,
    output state_t           o_dbg_state,
    output logic [CW-1:0]    o_dbg_bit_cnt
);

    localparam int            GAP_CYC  = 2 * GAP_BITS;
    localparam int            GW       = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_lsb;
    logic             r_tx_clk;
    logic             r_tx_data;
    logic [GW-1:0]    r_gap_cnt;

    logic             w_accept;
    logic             w_phase;
    logic             w_last;
    logic [CW-1:0]    w_bit_cnt;
    logic [WIDTH-1:0] w_next_shift;
    logic             w_serial_next;
    logic             w_next_bit;

    assign ready_out = (r_state == ST_IDLE) && ena;
    assign w_accept  = valid_in && ready_out;

    ser_tx_bitclk #(
        .NBITS (NBITS),
        .CW    (CW)
    ) u_bitclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept),
        .i_run   (r_state == ST_SHIFT),
        .o_phase (w_phase),
        .o_cnt   (w_bit_cnt),
        .o_last  (w_last)
    );

    // The bit on the lane always sits at the outgoing end of r_shift;
    // shifting toward that end exposes the next one.
    assign w_next_shift  = r_lsb ? (r_shift >> 1) : (r_shift << 1);
    assign w_serial_next = r_lsb ? w_next_shift[0] : w_next_shift[WIDTH-1];

`ifdef SER_TX_PARITY_EN
    localparam logic [CW-1:0] LAST_PAYLOAD = CW'(WIDTH - 1);
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_par <= 1'b0;
        else if (w_accept) r_par <= ^data_in;
    end

    // Leaving the last payload bit, the parity bit goes out next.
    assign w_next_bit = (w_bit_cnt == LAST_PAYLOAD) ? r_par : w_serial_next;
`else
    assign w_next_bit = w_serial_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_lsb     <= 1'b0;
            r_tx_clk  <= 1'b0;
            r_tx_data <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= data_in;
                        r_lsb     <= lsb_first;
                        r_tx_clk  <= 1'b0;
                        r_tx_data <= lsb_first ? data_in[0] : data_in[WIDTH-1];
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!w_phase) begin
                        r_tx_clk <= 1'b1;
                    end else if (w_last) begin
                        r_tx_clk  <= 1'b0;
                        r_tx_data <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else begin
                        // Data only changes as the lane clock falls.
                        r_tx_clk  <= 1'b0;
                        r_shift   <= w_next_shift;
                        r_tx_data <= w_next_bit;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_clk        = r_tx_clk;
    assign tx_data       = r_tx_data;
    assign busy          = (r_state != ST_IDLE);
    assign o_dbg_state   = r_state;
    assign o_dbg_bit_cnt = w_bit_cnt;

endmodule

// File: tb/tb_ser_tx.sv
module tb_ser_tx;
    import ser_tx_pkg::*;

    localparam int W = 16;
    localparam int G = 2;
`ifdef SER_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int CW       = $clog2(NB + 1);
    localparam int BUSY_LEN = 2 * NB + 2 * G;
    localparam int PERIOD   = 2 * NB + 2 * G + 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [W-1:0]  data_in;
    logic          valid_in;
    logic          ready_out;
    logic          lsb_first;
    logic          tx_clk;
    logic          tx_data;
    logic          busy;
    state_t        dbg_state;
    logic [CW-1:0] dbg_bit_cnt;

    always #5 clk = ~clk;

    ser_tx #(.WIDTH(W), .GAP_BITS(G)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .lsb_first     (lsb_first),
        .tx_clk        (tx_clk),
        .tx_data       (tx_data),
        .busy          (busy),
        .o_dbg_state   (dbg_state),
        .o_dbg_bit_cnt (dbg_bit_cnt)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [0:0]  exp_q[$];
    logic        cap_q[$];
    int          acc_q[$];
    int          gap_cyc = 0;
    int          gap_lo  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bit order straight from the word and the order flag,
    // parity (when built) appended as the XOR of the whole payload.
    function automatic void push_word(input logic [W-1:0] w, input logic lsb);
        for (int i = 0; i < W; i++)
            exp_q.push_back(lsb ? w[i] : w[W-1-i]);
`ifdef SER_TX_PARITY_EN
        exp_q.push_back(^w);
`endif
    endfunction

    // Monitor: samples on the falling edge, inputs change at posedge+1.
    initial begin : monitor
        logic prev_clk;
        logic prev_data;
        logic [0:0] e;
        prev_clk  = 1'b0;
        prev_data = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_clk  = 1'b0;
                prev_data = 1'b0;
            end else begin
                if (valid_in && ready_out) begin
                    push_word(data_in, lsb_first);
                    acc_q.push_back(cyc);
                end
                if (dbg_state == ST_GAP) begin
                    gap_cyc++;
                    if (!tx_clk) gap_lo++;
                end
                if (tx_clk && !prev_clk) begin
                    cap_q.push_back(tx_data);
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", 32'(tx_data), 32'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("serial_bit", 32'(tx_data), 32'(e));
                    end
                end
                if (tx_data != prev_data)
                    check("data_changes_clk_low", 32'(tx_clk), 32'd0);
                if (!busy)
                    check("idle_lane_low", {30'd0, tx_clk, tx_data}, 32'd0);
                prev_clk  = tx_clk;
                prev_data = tx_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and return just after the edge that accepts it.
    task automatic send(input logic [W-1:0] w, input logic lsb);
        int n;
        data_in   = w;
        lsb_first = lsb;
        valid_in  = 1'b1;
        n = 0;
        while (!ready_out && n < 300) begin
            tick();
            n++;
        end
        if (!ready_out) check("accept_timeout", 32'(n), 32'd0);
        tick();
        valid_in  = 1'b0;
        // Scramble inputs after acceptance; the word in flight must not change.
        data_in   = W'($urandom);
        lsb_first = 1'($urandom_range(0, 1));
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 500) begin
            cnt++;
            tick();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("drain_timeout", 32'(n), 32'd0);
    endtask

    function automatic logic [W-1:0] cap_stream();
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < W; i++)
            if (i < cap_q.size()) s[W-1-i] = cap_q[i];
        return s;
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         lsb;
        logic [W-1:0] exp_stream;  // first bit sent in the MSB
        logic         exp_par;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int bc;
        int d;
        logic [W-1:0] w;

        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b0};
        vecs[1] = '{16'hA5C3, 1'b1, 16'hC3A5, 1'b0};
        vecs[2] = '{16'h0007, 1'b0, 16'h0007, 1'b1};
        vecs[3] = '{16'h0003, 1'b1, 16'hC000, 1'b0};
        vecs[4] = '{16'h1234, 1'b1, 16'h2C48, 1'b1};
        vecs[5] = '{16'h8001, 1'b0, 16'h8001, 1'b0};
        vecs[6] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b0};

        rst_n = 1'b0; ena = 1'b0; valid_in = 1'b0; data_in = '0; lsb_first = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_tx_clk", 32'(tx_clk), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_bit_cnt", 32'(dbg_bit_cnt), 32'd0);
        check("rst_ready_ena0", 32'(ready_out), 32'd0);
        ena = 1'b1;
        #1;
        check("rst_ready_ena1", 32'(ready_out), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Table: bit order, parity, busy length.
        for (int i = 0; i < 7; i++) begin
            cap_q.delete();
            send(vecs[i].data, vecs[i].lsb);
            count_busy(bc);
            check("busy_len", 32'(bc), 32'(BUSY_LEN));
            wait_idle();
            check("bit_count", 32'(cap_q.size()), 32'(NB));
            check("stream", 32'(cap_stream()), 32'(vecs[i].exp_stream));
`ifdef SER_TX_PARITY_EN
            if (cap_q.size() > W) check("parity_bit", 32'(cap_q[W]), 32'(vecs[i].exp_par));
`endif
        end

        // Back-to-back with valid held: period and quiet gap.
        acc_q.delete();
        gap_cyc = 0;
        gap_lo  = 0;
        data_in = 16'h0001; lsb_first = 1'b0; valid_in = 1'b1;
        d = 0;
        while (acc_q.size() < 1 && d < 20) begin tick(); d++; end
        data_in = 16'hFFFF;
        d = 0;
        while (acc_q.size() < 2 && d < 200) begin tick(); d++; end
        valid_in = 1'b0;
        check("b2b_accepts", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2) check("b2b_period", 32'(acc_q[1] - acc_q[0]), 32'(PERIOD));
        wait_idle();
        check("gap_cycles", 32'(gap_cyc), 32'(4 * G));
        check("gap_clk_low", 32'(gap_lo), 32'(4 * G));

        // ena dropped mid-word: word completes, no new accept until ena returns.
        acc_q.delete();
        cap_q.delete();
        send(16'h1234, 1'b0);
        repeat (10) tick();
        ena = 1'b0;
        data_in = 16'h5555; lsb_first = 1'b0; valid_in = 1'b1;
        check("ena_word_continues", 32'(busy), 32'd1);
        d = 0;
        while (busy && d < 200) begin tick(); d++; end
        repeat (4) begin
            check("ena_low_ready", 32'(ready_out), 32'd0);
            tick();
        end
        check("ena_no_accept", 32'(acc_q.size()), 32'd1);
        check("ena_bits", 32'(cap_q.size()), 32'(NB));
        check("ena_stream", 32'(cap_stream()), 32'h1234);
        ena = 1'b1;
        #1;
        check("ena_back_ready", 32'(ready_out), 32'd1);
        tick();
        valid_in = 1'b0;
        check("ena_accepts", 32'(acc_q.size()), 32'd2);
        wait_idle();

        // Reset mid-word at bit 8 (phase 1, lane clock high).
        send(16'h0F0F, 1'b1);
        repeat (17) tick();
        check("mid_tx_clk_high", 32'(tx_clk), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_clk", 32'(tx_clk), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        cap_q.delete();
        send(16'hA5C3, 1'b0);
        count_busy(bc);
        check("post_rst_busy_len", 32'(bc), 32'(BUSY_LEN));
        wait_idle();
        check("post_rst_bits", 32'(cap_q.size()), 32'(NB));
        check("post_rst_stream", 32'(cap_stream()), 32'hA5C3);

        // Randomized words against the model.
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            cap_q.delete();
            w = W'($urandom);
            send(w, 1'($urandom_range(0, 1)));
            count_busy(bc);
            check("rand_busy_len", 32'(bc), 32'(BUSY_LEN));
            wait_idle();
            check("rand_bits", 32'(cap_q.size()), 32'(NB));
        end

        check("model_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the payload bits per word.
REQ-002 Parameter GAP_BITS, default 2, SHALL set the idle bit-times between words (range 1..15).
REQ-003 clk  input  1  SHALL be the single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ena  input  1  SHALL gate acceptance of new words; it does not stop a word in flight.
REQ-006 data_in  input  WIDTH  SHALL carry the word to send.
REQ-007 valid_in  input  1  SHALL indicate data_in is valid.
REQ-008 ready_out  output  1  SHALL indicate the block accepts a word this cycle.
REQ-009 lsb_first  input  1  SHALL select bit order; 0 = MSB first, 1 = LSB first; sampled only at accept.
REQ-010 tx_clk  output  1  SHALL be the forwarded lane clock driving the differential clock pad.
REQ-011 tx_data  output  1  SHALL be the serial data driving the differential data pad.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, SHIFT, GAP, encoded as a package enum.
REQ-014 ready_out SHALL equal (state==IDLE) && ena; accept = valid_in && ready_out.
REQ-015 On accept, data_in SHALL load a WIDTH-bit shift register, the order flag SHALL latch, and the state SHALL go to SHIFT next cycle.
REQ-016 Each bit SHALL last 2 clk cycles: phase 0 tx_clk=0, phase 1 tx_clk=1; tx_data SHALL change only entering phase 0.
REQ-017 The first bit SHALL appear on tx_data in the cycle after accept (latency 1); the receiver samples on the tx_clk rising edge.
REQ-018 A bit counter SHALL count 0..NBITS-1; after phase 1 of the last bit the state SHALL go to GAP.
REQ-019 In GAP and IDLE, tx_clk and tx_data SHALL be held 0.
REQ-020 GAP SHALL last exactly 2*GAP_BITS cycles, then go to IDLE.
REQ-021 With valid_in held high, word period SHALL be 2*NBITS + 2*GAP_BITS + 1 cycles (one IDLE cycle per word).
REQ-022 ena falling during SHIFT or GAP SHALL NOT abort the word; ready_out stays 0 until ena returns high in IDLE.
REQ-023 data_in and lsb_first changes after accept SHALL NOT affect the word in flight.
REQ-024 WIDTH is NBITS without parity; counters SHALL be sized $clog2(NBITS+1) bits and SHALL NOT wrap mid-word.

Reset
REQ-025 While rst_n=0: state=IDLE, tx_clk=0, tx_data=0, busy=0, counters and shift register 0; ready_out=ena.
REQ-026 Reset asserted mid-word SHALL drop tx_clk/tx_data to 0 at once; the partial word is discarded, not resumed.
REQ-027 Reset release SHALL take effect on the first rising clk edge after rst_n rises.

Configuration
REQ-028 With SER_TX_PARITY_EN defined, NBITS=WIDTH+1: an even-parity bit (XOR of the word) SHALL follow the last payload bit regardless of order.
REQ-029 Without SER_TX_PARITY_EN, NBITS=WIDTH and no parity logic SHALL exist.

Structure
REQ-030 Package ser_tx_pkg SHALL hold the state enum and the default WIDTH/GAP_BITS constants.
REQ-031 One sub-module, ser_tx_bitclk, SHALL generate the phase toggle and bit-count terminal pulse; the shifter and FSM stay in ser_tx.

Verification
REQ-032 Reset then accept 16'hA5C3, lsb_first=0 -> tx_data on successive tx_clk rises = 1010_0101_1100_0011; busy high 32+4 cycles.
REQ-033 Same word with lsb_first=1 -> 1100_0011_1010_0101 (bit0 first).
REQ-034 valid_in held high, words 16'h0001 then 16'hFFFF, GAP_BITS=2 -> second accept exactly 37 cycles after first; tx_clk low for the 4 gap cycles.
REQ-035 ena dropped at bit 5 of 16'h1234 -> all 16 bits sent; ready_out stays 0 until ena rises in IDLE.
REQ-036 rst_n pulsed low at bit 8 -> tx_clk=tx_data=0 same cycle; after release, next accept sends a full fresh word.
REQ-037 SER_TX_PARITY_EN, word 16'h0007 -> 17 bits, 17th bit=1; word 16'h0003 -> 17th bit=0; period 39 cycles.
